// File: rtl/wb_dbg_master_pkg.sv
// Shared constants and types for the serial-to-Wishbone debug bridge.
// Command/response bytes, FSM encoding and counter width.
package wb_dbg_master_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] CMD_PING = 8'h50;
    localparam logic [7:0] RSP_OK   = 8'h06;
    localparam logic [7:0] RSP_ERR  = 8'h15;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_TX,
        S_TX_WAIT
    } state_t;

endpackage

// File: rtl/wb_dbg_master.sv
// Serial-to-Wishbone debug bridge: decodes W/R/P byte commands,
// runs single classic bus cycles and serializes the response bytes.
module wb_dbg_master
    import wb_dbg_master_pkg::*;
#(
    parameter int unsigned bus_timeout = 1024,
    parameter int unsigned rx_timeout  = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    localparam logic [CNT_W-1:0] BUS_LAST = CNT_W'(bus_timeout - 1);
    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(rx_timeout - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [1:0]       tx_cnt;
    logic             cmd_wr;
    logic             ack_d;
    logic [31:0]      adr_sh;
    logic [31:0]      dat_sh;
    logic [31:0]      tx_sh;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] bus_cnt;
    logic             rx_state;
    logic             take;

    // A byte is consumed in the receive states, but never in the cycle
    // right after a consume since rx_valid has not dropped yet.
    assign rx_state = (state == S_IDLE) ||
                      (state == S_ADDR) ||
                      (state == S_DATA);
    assign take     = rx_valid && !ack_d && rx_state && !reset;
    assign rx_ack   = take;
    assign busy     = (state != S_IDLE);

    // Command decode, bus cycle and response serializer in one FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            byte_cnt <= 2'd0;
            tx_cnt   <= 2'd0;
            cmd_wr   <= 1'b0;
            ack_d    <= 1'b0;
            adr_sh   <= 32'h0;
            dat_sh   <= 32'h0;
            tx_sh    <= 32'h0;
            rx_cnt   <= '0;
            bus_cnt  <= '0;
            tx_data  <= 8'h0;
            tx_wr    <= 1'b0;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            ack_d <= take;
            tx_wr <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        byte_cnt <= 2'd0;
                        rx_cnt   <= '0;
                        case (rx_data)
                            CMD_WR: begin
                                cmd_wr <= 1'b1;
                                state  <= S_ADDR;
                            end
                            CMD_RD: begin
                                cmd_wr <= 1'b0;
                                state  <= S_ADDR;
                            end
                            CMD_PING: begin
                                tx_sh  <= {RSP_OK, 24'h0};
                                tx_cnt <= 2'd0;
                                state  <= S_TX;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (take) begin
                        adr_sh   <= {adr_sh[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        rx_cnt   <= '0;
                        if (byte_cnt == 2'd3) begin
                            if (cmd_wr) begin
                                state <= S_DATA;
                            end else begin
                                wb_adr_o <= {adr_sh[23:0], rx_data};
                                wb_we_o  <= 1'b0;
                                wb_sel_o <= 4'hF;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                bus_cnt  <= '0;
                                state    <= S_BUS;
                            end
                        end
                    end else if (rx_cnt == RX_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (take) begin
                        dat_sh   <= {dat_sh[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        rx_cnt   <= '0;
                        if (byte_cnt == 2'd3) begin
                            wb_adr_o <= adr_sh;
                            wb_dat_o <= {dat_sh[23:0], rx_data};
                            wb_we_o  <= 1'b1;
                            wb_sel_o <= 4'hF;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            bus_cnt  <= '0;
                            state    <= S_BUS;
                        end
                    end else if (rx_cnt == RX_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                S_BUS: begin
                    if (wb_ack_i || bus_cnt == BUS_LAST) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= 4'h0;
                        state    <= S_TX;
                        if (wb_ack_i && !wb_we_o) begin
                            tx_sh  <= wb_dat_i;
                            tx_cnt <= 2'd3;
                        end else if (wb_ack_i) begin
                            tx_sh  <= {RSP_OK, 24'h0};
                            tx_cnt <= 2'd0;
                        end else begin
                            tx_sh  <= {RSP_ERR, 24'h0};
                            tx_cnt <= 2'd0;
                        end
                    end else begin
                        bus_cnt <= bus_cnt + CNT_ONE;
                    end
                end
                S_TX: begin
                    if (!tx_busy) begin
                        tx_data <= tx_sh[31:24];
                        tx_sh   <= {tx_sh[23:0], 8'h0};
                        tx_wr   <= 1'b1;
                        state   <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (tx_cnt == 2'd0) begin
                        state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 2'd1;
                        state  <= S_TX;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// Directed bench for wb_dbg_master: write/read, bus timeout, ping,
// garbage, inter-byte timeout, tx backpressure and reset mid-cycle.
module tb_wb_dbg_master;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        busy;

    int checks;
    int errors;

    logic [31:0] mem;
    logic        slave_en;

    int          bus_cycles;
    int          cyc_cycles;
    int          ack_cnt;
    int          wr_multi;
    logic        cyc_prev;
    logic        wr_prev;
    logic [31:0] cap_adr;
    logic [31:0] cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;
    logic [7:0]  txq[$];

    wb_dbg_master #(
        .bus_timeout(16),
        .rx_timeout (100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ack  (rx_ack),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_busy (tx_busy),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o),
        .wb_we_o (wb_we_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-word bram-like slave acking one cycle after strobe.
    initial begin
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        mem      = 32'h0;
    end
    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && slave_en && !wb_ack_i) begin
            wb_ack_i <= 1'b1;
            wb_dat_i <= mem;
            if (wb_we_o) mem <= wb_dat_o;
        end else begin
            wb_ack_i <= 1'b0;
        end
    end

    // Passive monitor sampling on the falling edge.
    initial begin
        bus_cycles = 0;
        cyc_cycles = 0;
        ack_cnt    = 0;
        wr_multi   = 0;
        cyc_prev   = 1'b0;
        wr_prev    = 1'b0;
        cap_adr    = 32'h0;
        cap_dat    = 32'h0;
        cap_we     = 1'b0;
        cap_sel    = 4'h0;
    end
    always @(negedge clk) begin
        if (wb_cyc_o) cyc_cycles++;
        if (wb_cyc_o && !cyc_prev) begin
            bus_cycles++;
            cap_adr = wb_adr_o;
            cap_dat = wb_dat_o;
            cap_we  = wb_we_o;
            cap_sel = wb_sel_o;
        end
        cyc_prev = wb_cyc_o;
        if (tx_wr) begin
            txq.push_back(tx_data);
            if (wr_prev) wr_multi++;
        end
        wr_prev = tx_wr;
        if (rx_ack) ack_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rx_ack byte %02h: got no pulse, required one", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_idle: busy=%0b required 0", tag, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [81:0] outs;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h0;
        tx_busy  = 1'b0;
        slave_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outs = {rx_ack, tx_data, tx_wr, wb_adr_o, wb_dat_o,
                wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h required 0", outs);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        int b_bus;
        int b_tx;
        b_bus = bus_cycles;
        b_tx  = txq.size();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        wait_idle(200, "wr");
        checks++;
        if (bus_cycles - b_bus !== 1) begin
            errors++;
            $display("FAIL wr_cycles: got %0d required 1",
                     bus_cycles - b_bus);
        end
        checks++;
        if (cap_adr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL wr_adr: got %h required 00001000", cap_adr);
        end
        checks++;
        if (cap_dat !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_dat: got %h required deadbeef", cap_dat);
        end
        checks++;
        if ({cap_we, cap_sel} !== 5'h1F) begin
            errors++;
            $display("FAIL wr_we_sel: got %b required 11111",
                     {cap_we, cap_sel});
        end
        checks++;
        if (mem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_mem: got %h required deadbeef", mem);
        end
        checks++;
        if (txq.size() - b_tx !== 1 || txq[b_tx] !== 8'h06) begin
            errors++;
            $display("FAIL wr_rsp: got %0d bytes required one 06",
                     txq.size() - b_tx);
        end
    endtask

    task automatic test_read();
        int          b_tx;
        logic [31:0] exp;
        exp  = 32'hDEAD_BEEF;
        b_tx = txq.size();
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        wait_idle(200, "rd");
        checks++;
        if (cap_we !== 1'b0 || cap_adr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL rd_bus: got we=%b adr=%h required 0 00001000",
                     cap_we, cap_adr);
        end
        checks++;
        if (txq.size() - b_tx !== 4) begin
            errors++;
            $display("FAIL rd_count: got %0d required 4",
                     txq.size() - b_tx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (txq[b_tx + i] !== exp[31 - 8 * i -: 8]) begin
                    errors++;
                    $display("FAIL rd_byte%0d: got %02h required %02h",
                             i, txq[b_tx + i], exp[31 - 8 * i -: 8]);
                end
            end
        end
    endtask

    task automatic test_bus_timeout();
        int b_cyc;
        int b_tx;
        slave_en = 1'b0;
        b_cyc    = cyc_cycles;
        b_tx     = txq.size();
        send_byte(8'h52);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle(200, "bto");
        checks++;
        if (cyc_cycles - b_cyc !== 16) begin
            errors++;
            $display("FAIL bto_cyc_len: got %0d required 16",
                     cyc_cycles - b_cyc);
        end
        checks++;
        if (cap_adr !== 32'h4000_0000) begin
            errors++;
            $display("FAIL bto_adr: got %h required 40000000", cap_adr);
        end
        checks++;
        if (txq.size() - b_tx !== 1 || txq[b_tx] !== 8'h15) begin
            errors++;
            $display("FAIL bto_rsp: got %0d bytes required one 15",
                     txq.size() - b_tx);
        end
        checks++;
        if (wb_cyc_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bto_end: got cyc=%b busy=%b required 0 0",
                     wb_cyc_o, busy);
        end
        slave_en = 1'b1;
    endtask

    task automatic test_ping_garbage();
        int b_bus;
        int b_tx;
        int b_ack;
        b_bus = bus_cycles;
        b_tx  = txq.size();
        send_byte(8'h50);
        wait_idle(50, "ping");
        checks++;
        if (txq.size() - b_tx !== 1 || txq[b_tx] !== 8'h06) begin
            errors++;
            $display("FAIL ping_rsp: got %0d bytes required one 06",
                     txq.size() - b_tx);
        end
        b_tx  = txq.size();
        b_ack = ack_cnt;
        send_byte(8'hAA);
        repeat (20) @(negedge clk);
        checks++;
        if (ack_cnt - b_ack !== 1) begin
            errors++;
            $display("FAIL junk_ack: got %0d pulses required 1",
                     ack_cnt - b_ack);
        end
        checks++;
        if (txq.size() !== b_tx || busy !== 1'b0) begin
            errors++;
            $display("FAIL junk_quiet: got tx=%0d busy=%b required 0 0",
                     txq.size() - b_tx, busy);
        end
        checks++;
        if (bus_cycles !== b_bus) begin
            errors++;
            $display("FAIL ping_junk_bus: got %0d cycles required 0",
                     bus_cycles - b_bus);
        end
    endtask

    task automatic test_rx_timeout();
        int b_bus;
        int b_tx;
        b_bus = bus_cycles;
        b_tx  = txq.size();
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (150) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rxto_idle: got busy=%b required 0", busy);
        end
        checks++;
        if (bus_cycles !== b_bus || txq.size() !== b_tx) begin
            errors++;
            $display("FAIL rxto_quiet: got bus=%0d tx=%0d required 0 0",
                     bus_cycles - b_bus, txq.size() - b_tx);
        end
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        wait_idle(200, "rxto_wr");
        checks++;
        if (cap_adr !== 32'h0000_2000 || cap_dat !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rxto_wr: got %h/%h required 00002000/12345678",
                     cap_adr, cap_dat);
        end
        checks++;
        if (txq.size() - b_tx !== 1 || txq[b_tx] !== 8'h06) begin
            errors++;
            $display("FAIL rxto_rsp: got %0d bytes required one 06",
                     txq.size() - b_tx);
        end
    endtask

    task automatic test_backpressure();
        int          b_tx;
        int          b_multi;
        logic [31:0] exp;
        exp     = 32'h1234_5678;
        b_tx    = txq.size();
        b_multi = wr_multi;
        tx_busy = 1'b1;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h00);
        repeat (50) @(negedge clk);
        checks++;
        if (txq.size() !== b_tx || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got tx=%0d busy=%b required 0 1",
                     txq.size() - b_tx, busy);
        end
        tx_busy = 1'b0;
        wait_idle(100, "bp");
        checks++;
        if (txq.size() - b_tx !== 4) begin
            errors++;
            $display("FAIL bp_count: got %0d required 4",
                     txq.size() - b_tx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (txq[b_tx + i] !== exp[31 - 8 * i -: 8]) begin
                    errors++;
                    $display("FAIL bp_byte%0d: got %02h required %02h",
                             i, txq[b_tx + i], exp[31 - 8 * i -: 8]);
                end
            end
        end
        checks++;
        if (wr_multi !== b_multi) begin
            errors++;
            $display("FAIL bp_pulse: got %0d long pulses required 0",
                     wr_multi - b_multi);
        end
    endtask

    task automatic test_reset_in_bus();
        int          b_tx;
        logic [81:0] outs;
        slave_en = 1'b0;
        b_tx     = txq.size();
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        checks++;
        if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin
            errors++;
            $display("FAIL rst_bus_pre: got cyc/stb=%b required 11",
                     {wb_cyc_o, wb_stb_o});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        outs = {rx_ack, tx_data, tx_wr, wb_adr_o, wb_dat_o,
                wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_bus_outs: got %h required 0", outs);
        end
        reset    = 1'b0;
        slave_en = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (txq.size() !== b_tx || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_bus_quiet: got tx=%0d cyc=%b required 0 0",
                     txq.size() - b_tx, wb_cyc_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write();
        test_read();
        test_bus_timeout();
        test_ping_garbage();
        test_rx_timeout();
        test_backpressure();
        test_reset_in_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
